// File: rtl/led_scan_ctrl_pkg.sv
// Shared types and defaults for the multiplexed LED scan controller.
package led_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BLANK,
      ST_DRIVE
   } scan_state_e;

   localparam int DEF_NUM_COLS = 5;
   localparam int DEF_NUM_ROWS = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/led_dwell_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module led_dwell_timer #(
   parameter int WIDTH = 14
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - WIDTH'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/led_scan_ctrl.sv
// Column-multiplexed LED scanner: double-buffered frame, blank gap before each
// column, frame swap only at the column-0 boundary.
module led_scan_ctrl
   import led_scan_ctrl_pkg::*;
#(
   parameter int NUM_COLS     = DEF_NUM_COLS,
   parameter int NUM_ROWS     = DEF_NUM_ROWS,
   parameter int DWELL_CYCLES = 10000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [NUM_COLS*NUM_ROWS-1:0] grid_in,
   input  logic                         grid_valid,
   output logic                         grid_ready,
   output logic [NUM_COLS-1:0]          col_active,
   output logic [NUM_ROWS-1:0]          row_data,
   output logic                         frame_start,
   output logic                         display_on
);

   localparam int GRID_W = NUM_COLS * NUM_ROWS;
   localparam int IDX_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int CNT_W  = $clog2(max_int(DWELL_CYCLES, BLANK_CYCLES) + 1);

   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_COLS - 1);

   scan_state_e         state;
   logic [IDX_W-1:0]    col_idx;
   logic                pending_full;
   logic [GRID_W-1:0]   shadow_buf;
   logic [GRID_W-1:0]   active_buf;

   logic                tmr_load;
   logic [CNT_W-1:0]    tmr_value;
   logic                tmr_done;
   logic                frame_boundary;
   logic [NUM_COLS-1:0] col_onehot;
   logic [NUM_ROWS-1:0] col_byte;

   assign grid_ready = ~pending_full;

   // Timer loads with N-1 on each state entry, so done marks the last cycle of that state.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      tmr_load       = 1'b0;
      tmr_value      = '0;
      frame_boundary = 1'b0;
      if (!enable) begin
         tmr_load = 1'b1;
      end else begin
         unique case (state)
            ST_IDLE: if (display_on || pending_full) begin
               tmr_load       = 1'b1;
               tmr_value      = BLANK_LOAD;
               frame_boundary = 1'b1;
            end
            ST_BLANK: if (tmr_done) begin
               tmr_load  = 1'b1;
               tmr_value = DWELL_LOAD;
            end
            ST_DRIVE: if (tmr_done) begin
               tmr_load       = 1'b1;
               tmr_value      = BLANK_LOAD;
               frame_boundary = (col_idx == LAST_IDX);
            end
            default: ;
         endcase
      end
   end

   // Index 0 is column 1, which lives in the MSB column bit and the MSB byte.
   always_comb begin
      col_onehot = '0;
      col_byte   = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         if (int'(col_idx) == c) begin
            col_onehot[NUM_COLS-1-c] = 1'b1;
            col_byte = active_buf[(NUM_COLS-1-c)*NUM_ROWS +: NUM_ROWS];
         end
      end
   end

   led_dwell_timer #(.WIDTH(CNT_W)) u_timer (
      .clock      (clock),
      .reset      (reset),
      .load       (tmr_load),
      .load_value (tmr_value),
      .done       (tmr_done)
   );

   // NOTE: frame buffers are reset too, so a stale frame can never be shown after reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         col_idx      <= '0;
         pending_full <= 1'b0;
         shadow_buf   <= '0;
         active_buf   <= '0;
         col_active   <= '0;
         row_data     <= '0;
         frame_start  <= 1'b0;
         display_on   <= 1'b0;
      end else begin
         frame_start <= frame_boundary;

         if (grid_valid && !pending_full) begin
            shadow_buf   <= grid_in;
            pending_full <= 1'b1;
         end

         // Capture needs !pending_full and the swap needs pending_full, so they never collide.
         if (frame_boundary && pending_full) begin
            active_buf   <= shadow_buf;
            pending_full <= 1'b0;
            display_on   <= 1'b1;
         end

         if (!enable) begin
            state      <= ST_IDLE;
            col_idx    <= '0;
            col_active <= '0;
            row_data   <= '0;
         end else begin
            unique case (state)
               ST_IDLE: if (display_on || pending_full) begin
                  state   <= ST_BLANK;
                  col_idx <= '0;
               end
               ST_BLANK: if (tmr_done) begin
                  state      <= ST_DRIVE;
                  col_active <= col_onehot;
                  row_data   <= col_byte;
               end
               ST_DRIVE: if (tmr_done) begin
                  state      <= ST_BLANK;
                  col_active <= '0;
                  row_data   <= '0;
                  col_idx    <= (col_idx == LAST_IDX) ? '0 : col_idx + IDX_W'(1);
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with DWELL_CYCLES=4, BLANK_CYCLES=2 (30-cycle frame).
module tb_led_scan_ctrl;

   localparam int NC = 5;
   localparam int NR = 8;
   localparam int FRAME = 30;

   logic           clock = 1'b0;
   logic           reset;
   logic           enable;
   logic [39:0]    grid_in;
   logic           grid_valid;
   logic           grid_ready;
   logic [NC-1:0]  col_active;
   logic [NR-1:0]  row_data;
   logic           frame_start;
   logic           display_on;

   int total = 0;
   int bad   = 0;

   logic [39:0] frame_a = 40'h80_40_20_10_08;
   logic [39:0] frame_b = 40'hFF_00_FF_00_FF;
   logic [39:0] frame_c = 40'h12_34_56_78_9A;

   always #5 clock = ~clock;

   led_scan_ctrl #(
      .NUM_COLS     (NC),
      .NUM_ROWS     (NR),
      .DWELL_CYCLES (4),
      .BLANK_CYCLES (2)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .grid_in     (grid_in),
      .grid_valid  (grid_valid),
      .grid_ready  (grid_ready),
      .col_active  (col_active),
      .row_data    (row_data),
      .frame_start (frame_start),
      .display_on  (display_on)
   );

   // k = samples since the boundary edge: 2 blank cycles then 4 drive cycles per column.
   function automatic logic [NC-1:0] exp_col(input int k);
      logic [NC-1:0] top = 5'b10000;
      if ((k % 6) < 2) return '0;
      return top >> (k / 6);
   endfunction

   function automatic logic [NR-1:0] exp_row(input logic [39:0] f, input int k);
      if ((k % 6) < 2) return '0;
      return f[39 - 8*(k/6) -: 8];
   endfunction

   // Checks one whole frame; call when the next rising edge is a frame boundary.
   // Optionally offers inj_data at sample inj_k and expects it taken by sample drop_k.
   task automatic expect_frame(input logic [39:0] f, input string tag, input int inj_k,
                               input logic [39:0] inj_data, input logic ready_k0,
                               input int drop_k);
      for (int k = 0; k < FRAME; k++) begin
         @(negedge clock);
         total++;
         if (col_active !== exp_col(k) || row_data !== exp_row(f, k)) begin
            bad++;
            $display("FAIL %s k=%0d col/row: got %b/%h want %b/%h", tag, k,
                     col_active, row_data, exp_col(k), exp_row(f, k));
         end
         total++;
         if (frame_start !== (k == 0)) begin
            bad++;
            $display("FAIL %s k=%0d frame_start: got %b want %b", tag, k, frame_start, k == 0);
         end
         total++;
         if (display_on !== 1'b1) begin
            bad++;
            $display("FAIL %s k=%0d display_on: got %b want 1", tag, k, display_on);
         end
         if (k == 0) begin
            total++;
            if (grid_ready !== ready_k0) begin
               bad++;
               $display("FAIL %s grid_ready@boundary: got %b want %b", tag, grid_ready, ready_k0);
            end
         end
         if (k == inj_k) begin
            grid_in    = inj_data;
            grid_valid = 1'b1;
         end
         if (k == drop_k) begin
            total++;
            if (grid_ready !== 1'b0) begin
               bad++;
               $display("FAIL %s grid_ready after capture: got %b want 0", tag, grid_ready);
            end
            grid_valid = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; grid_valid = 1'b0; grid_in = '0;
      repeat (2) @(negedge clock);
      total++;
      if ({col_active, row_data, frame_start, display_on} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 0", {col_active, row_data, frame_start, display_on});
      end
      reset = 1'b0;
      @(negedge clock);
      total++;
      if (grid_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: got %b want 1", grid_ready);
      end
   endtask

   task automatic test_first_frame();
      grid_in = frame_a; grid_valid = 1'b1; enable = 1'b1;
      @(negedge clock);
      total++;
      if (grid_ready !== 1'b0 || frame_start !== 1'b0 || display_on !== 1'b0) begin
         bad++;
         $display("FAIL first_capture ready/fs/on: got %b%b%b want 000", grid_ready, frame_start, display_on);
      end
      grid_valid = 1'b0;
      expect_frame(frame_a, "frame_a", -1, '0, 1'b1, -1);
   endtask

   task automatic test_steady_scan();
      int first_fs = -1;
      int second_fs = -1;
      int pulses = 0;
      int lit = 0;
      for (int k = 0; k < 2*FRAME; k++) begin
         @(negedge clock);
         total++;
         if (!$onehot0(col_active)) begin
            bad++;
            $display("FAIL steady_onehot k=%0d: got %b want one-hot or zero", k, col_active);
         end
         if (col_active != '0) lit++;
         if (frame_start) begin
            pulses++;
            if (first_fs < 0) first_fs = k; else if (second_fs < 0) second_fs = k;
         end
      end
      total++;
      if (pulses != 2 || (second_fs - first_fs) != FRAME) begin
         bad++;
         $display("FAIL steady_period: got pulses=%0d period=%0d want 2/%0d", pulses, second_fs - first_fs, FRAME);
      end
      total++;
      if (lit != 40) begin
         bad++;
         $display("FAIL steady_duty: got %0d lit cycles want 40", lit);
      end
   endtask

   // B offered mid column 3 of A; C then held across the boundary while the shadow is full.
   task automatic test_back_to_back();
      expect_frame(frame_a, "a_while_b_pending", 15, frame_b, 1'b1, 16);
      grid_in = frame_c; grid_valid = 1'b1;
      expect_frame(frame_b, "b_while_c_held", -1, '0, 1'b1, 1);
      expect_frame(frame_c, "frame_c", -1, '0, 1'b1, -1);
   endtask

   task automatic test_enable_drop();
      for (int k = 0; k < 22; k++) @(negedge clock);
      total++;
      if (col_active !== 5'b00010 || row_data !== frame_c[15:8]) begin
         bad++;
         $display("FAIL col4_before_drop: got %b/%h want 00010/%h", col_active, row_data, frame_c[15:8]);
      end
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         total++;
         if (col_active !== '0 || row_data !== '0 || frame_start !== 1'b0) begin
            bad++;
            $display("FAIL disabled_outputs k=%0d: got %b/%h/%b want 0", k, col_active, row_data, frame_start);
         end
      end
      enable = 1'b1;
      expect_frame(frame_c, "restart_c", -1, '0, 1'b1, -1);
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 4; k++) @(negedge clock);
      total++;
      if (col_active !== 5'b10000) begin
         bad++;
         $display("FAIL pre_reset_drive: got %b want 10000", col_active);
      end
      reset = 1'b1; grid_in = frame_a; grid_valid = 1'b1;
      @(negedge clock);
      total++;
      if ({col_active, row_data, frame_start, display_on} !== '0) begin
         bad++;
         $display("FAIL mid_reset_outputs: got %b want 0", {col_active, row_data, frame_start, display_on});
      end
      reset = 1'b0; grid_valid = 1'b0;
      @(negedge clock);
      total++;
      if (grid_ready !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset_no_capture: grid_ready got %b want 1", grid_ready);
      end
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         total++;
         if (col_active !== '0 || frame_start !== 1'b0 || display_on !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_frame k=%0d: got %b/%b/%b want 0", k, col_active, frame_start, display_on);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_steady_scan();
      test_back_to_back();
      test_enable_drop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_COLS, default 5, number of multiplexed LED columns.
REQ-002 SHALL have parameter NUM_ROWS, default 8, row bits per column.
REQ-003 SHALL have parameter DWELL_CYCLES, default 10000, clocks each column is driven (200 us at 50 MHz).
REQ-004 SHALL have parameter BLANK_CYCLES, default 500, all-off clocks before each column (anti-ghosting).
REQ-005 SHALL have port clock, input, 1, sole clock.
REQ-006 SHALL have port reset, input, 1, reset.
REQ-007 Clocking and reset SHALL be one clock, with reset synchronous and active-high.
REQ-008 SHALL have port enable, input, 1, scan permitted.
REQ-009 SHALL have port grid_in, input, NUM_COLS*NUM_ROWS, frame; column 1 in the MSB byte, row 1 in the MSB of each byte.
REQ-010 SHALL have port grid_valid, input, 1, producer offers grid_in.
REQ-011 SHALL have port grid_ready, output, 1, shadow buffer empty and able to accept a frame.
REQ-012 SHALL have port col_active, output, NUM_COLS, one-hot active-high column select; column 1 is the MSB.
REQ-013 SHALL have port row_data, output, NUM_ROWS, active-high row drive for the selected column.
REQ-014 SHALL have port frame_start, output, 1, one-cycle pulse at each frame boundary.
REQ-015 SHALL have port display_on, output, 1, an active frame has been loaded.

Function
REQ-016 Buffering SHALL be double: shadow (pending) plus active, with a pending_full flag; grid_ready = ~pending_full.
REQ-017 On grid_valid & grid_ready at an edge, grid_in SHALL be captured into the shadow and pending_full set; grid_valid while not ready SHALL be ignored and the producer SHALL hold it.
REQ-018 Frame boundary SHALL be the transition into BLANK for column index 0; if pending_full there, shadow→active, pending_full cleared, display_on set (sticky until reset).
REQ-019 The active buffer SHALL change only at a frame boundary; no tearing mid-frame.
REQ-020 FSM SHALL have states IDLE, BLANK, DRIVE, with a column index 0..NUM_COLS-1 and a dwell counter sized to max(DWELL_CYCLES, BLANK_CYCLES).
REQ-021 IDLE SHALL go to BLANK (index 0, frame boundary) when enable & (display_on | pending_full); otherwise it stays in IDLE.
REQ-022 BLANK SHALL last exactly BLANK_CYCLES cycles, then go to DRIVE.
REQ-023 DRIVE SHALL last exactly DWELL_CYCLES cycles; then if index < NUM_COLS-1, index+1 → BLANK; else index 0 → BLANK (frame boundary).
REQ-024 Outputs SHALL be registered and update on the same edge as the state; col_active and row_data SHALL be nonzero only in DRIVE.
REQ-025 In DRIVE, col_active SHALL have only bit (NUM_COLS-1-index) set and row_data SHALL equal the active byte for that column.
REQ-026 frame_start SHALL be high for exactly the one cycle following each frame-boundary edge.
REQ-027 enable low SHALL force IDLE at the next edge from any state: index 0, outputs zero next cycle, buffers kept.
REQ-028 Frame period SHALL be NUM_COLS*(BLANK_CYCLES+DWELL_CYCLES) cycles with no idle gaps while enabled.
REQ-029 Output polarity SHALL be active-high only; pin mapping and column inversion belong to the top level.

Reset
REQ-030 Reset SHALL set state IDLE, index 0, counter 0, pending_full 0, active and shadow buffers 0, and col_active, row_data, frame_start, display_on to 0; grid_ready SHALL be 1 the cycle after reset.
REQ-031 Reset asserted mid-frame SHALL take priority over every other event, including a same-edge grid capture, which SHALL be discarded.

Structure
REQ-032 The shared package SHALL hold the state enum (IDLE, BLANK, DRIVE) and the default NUM_COLS/NUM_ROWS constants.
REQ-033 One sub-module, led_dwell_timer (loadable down-counter with a done flag), SHALL be natural; the FSM and buffers stay in led_scan_ctrl.

Verification (bench parameters DWELL_CYCLES=4, BLANK_CYCLES=2)
REQ-034 Reset then enable=1, grid_in=40'h80_40_20_10_08 accepted at edge E0 -> frame_start high after E1; col_active=5'b10000, row_data=8'h80 first visible after E3 for 4 cycles; then 2 blank cycles; then 5'b01000/8'h40, and so on.
REQ-035 Steady scan -> frame_start period is exactly 30 cycles; each col_active is one-hot or zero; nonzero for 20 of every 30 cycles.
REQ-036 Load frame B (40'hFF_00_FF_00_FF) while frame A is in the middle of column 3 -> grid_ready falls; A finishes unchanged; B appears from the next column 1; grid_ready rises one cycle after the boundary.
REQ-037 grid_valid held while grid_ready=0, with a third frame C -> C is not captured until grid_ready=1, then accepted on that edge.
REQ-038 Drop enable during DRIVE of column 4 -> outputs zero the next cycle; re-enable -> restarts at column 1 with BLANK and a frame_start pulse.
REQ-039 Assert reset in DRIVE with grid_valid=1 on the same edge -> all outputs 0, display_on=0, no capture; enable with no frame keeps the FSM in IDLE.
